// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage
// Execute-to-memory pipeline register with a two-entry skid buffer.
// The main entry drives the mem_* outputs; the skid entry absorbs one
// extra result when memory stalls, so ex_ready can be a registered signal
// (ex_ready = !skid_valid) with no combinational path from mem_ready.
//
// Optional build macro: EX_MEM_FLAGS_EN adds mem_zero / mem_neg result flags,
// computed at capture time and carried with the entry.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-low reset
//   flush           synchronous kill of all held entries
//   ex_valid/ready  upstream handshake (ex_ready registered)
//   ex_result/store/rd/ctrl  upstream payload
//   mem_valid/ready downstream handshake
//   mem_result/store/rd/ctrl registered downstream payload
//   occupancy       number of valid entries held (0..2), registered
//   mem_zero/neg    (EX_MEM_FLAGS_EN only) flags of the presented result

module ex_mem_skid_stage #(
    parameter int unsigned N     = 16,
    parameter int unsigned REGW  = 4,
    parameter int unsigned CTRLW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [N-1:0]     ex_result,
    input  logic [N-1:0]     ex_store,
    input  logic [REGW-1:0]  ex_rd,
    input  logic [CTRLW-1:0] ex_ctrl,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [N-1:0]     mem_result,
    output logic [N-1:0]     mem_store,
    output logic [REGW-1:0]  mem_rd,
    output logic [CTRLW-1:0] mem_ctrl,
`ifdef EX_MEM_FLAGS_EN
    output logic             mem_zero,
    output logic             mem_neg,
`endif
    output logic [1:0]       occupancy
);

    // One buffered entry's payload.
    typedef struct packed {
        logic [N-1:0]     result;
        logic [N-1:0]     store;
        logic [REGW-1:0]  rd;
        logic [CTRLW-1:0] ctrl;
`ifdef EX_MEM_FLAGS_EN
        logic             zero;
        logic             neg;
`endif
    } entry_t;

    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       main_v_q, main_v_d;
    logic       skid_v_q, skid_v_d;
    logic       ready_q, ready_d;
    logic [1:0] occ_q, occ_d;

    logic   accept_c;
    logic   emit_c;
    entry_t incoming_c;

    // Pack the upstream payload (and derived flags) into an entry.
    always_comb begin
        incoming_c        = '0;
        incoming_c.result = ex_result;
        incoming_c.store  = ex_store;
        incoming_c.rd     = ex_rd;
        incoming_c.ctrl   = ex_ctrl;
`ifdef EX_MEM_FLAGS_EN
        incoming_c.zero   = (ex_result == '0);
        incoming_c.neg    = ex_result[N-1];
`endif
    end

    assign accept_c = ex_valid && ready_q;
    assign emit_c   = main_v_q && mem_ready;

    // Next-state for the two entries; data regs hold unless loaded.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;

        if (flush) begin
            // Accept is dropped; a same-edge emit has already completed.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (accept_c) begin
                main_d   = incoming_c;
                main_v_d = 1'b1;
            end
        end else if (!skid_v_q) begin
            if (accept_c && emit_c) begin
                main_d = incoming_c;
            end else if (accept_c) begin
                skid_d   = incoming_c;
                skid_v_d = 1'b1;
            end else if (emit_c) begin
                main_v_d = 1'b0;
            end
        end else begin
            // Full: ex_ready is low so no accept can happen here.
            if (emit_c) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end

        ready_d = !skid_v_d;
        occ_d   = 2'(main_v_d) + 2'(skid_v_d);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
            occ_q    <= 2'd0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
            occ_q    <= occ_d;
        end
    end

    assign ex_ready   = ready_q;
    assign mem_valid  = main_v_q;
    assign mem_result = main_q.result;
    assign mem_store  = main_q.store;
    assign mem_rd     = main_q.rd;
    assign mem_ctrl   = main_q.ctrl;
    assign occupancy  = occ_q;
`ifdef EX_MEM_FLAGS_EN
    assign mem_zero   = main_q.zero;
    assign mem_neg    = main_q.neg;
`endif

endmodule
